// File: rtl/ccr_branch_unit.sv
// ---------------------------------------------------------------------------
// ccr_branch_unit
//
// Purpose:
//   This is the sequential stage that follows the combinational
//   condition-code logic.
//   - It holds the architectural CCR. Every accepted instruction commits
//     ccr_next, and ccr_q is fed back to the flag logic.
//   - On a taken branch it latches the branch target and raises a
//     valid/ready redirect request to fetch.
//   - Once fetch accepts the redirect, it holds flush high for exactly
//     FLUSH_CYCLES cycles, then returns to IDLE.
//
// Parameters:
//   XLEN         - datapath width of pc_in, br_offset and redirect_pc.
//   CCR_USED     - number of live CCR bits. Bits above these are always
//                  stored as 0.
//   FLUSH_CYCLES - number of cycles flush stays high after the redirect is
//                  accepted. Legal range is 1..15.
//
// Optional feature (compile-time macro CCR_BRANCH_STATS_EN):
//   defined   - br_count is a saturating 16-bit count of taken branches.
//   undefined - br_count is tied to 0 and no counter flops are built.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   valid_in       in   execute-stage instruction valid
//   stall          in   pipeline stall; blocks acceptance
//   ccr_next       in   next CCR value from the flag logic
//   br_taken       in   branch-taken decision from the flag logic
//   pc_in          in   PC of the execute-stage instruction
//   br_offset      in   signed branch offset in bytes
//   ccr_q          out  registered CCR
//   redirect_valid out  redirect request to fetch
//   redirect_pc    out  branch target, word aligned; stable while valid
//   redirect_ready in   fetch accepts the redirect
//   flush          out  squash younger pipeline stages
//   busy           out  unit not idle; upstream must hold its instruction
//   br_count       out  taken-branch counter (0 unless stats are enabled)
// ---------------------------------------------------------------------------
module ccr_branch_unit #(
    parameter int XLEN         = 32,
    parameter int CCR_USED     = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            stall,
    input  logic [31:0]     ccr_next,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] br_offset,
    output logic [31:0]     ccr_q,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     br_count
);

    localparam int          CNT_W    = 4;
    localparam logic [31:0] CCR_MASK = (CCR_USED >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << CCR_USED) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ccr_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ccr_reg_q;

    logic              acc;
    logic [XLEN-1:0]   target_sum;
    logic [XLEN-1:0]   target_aligned;

    // Instructions are only taken while idle. A pending redirect or flush
    // makes the unit deaf to valid_in and br_taken.
    assign acc = valid_in & ~stall & (state_q == S_IDLE);

    // The sum wraps silently modulo 2^XLEN. Targets are word aligned, so
    // the two low bits are dropped.
    assign target_sum     = pc_in + br_offset;
    assign target_aligned = {target_sum[XLEN-1:2], 2'b00};

    always_comb begin
        state_d          = state_q;
        ccr_d            = ccr_reg_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = redirect_valid_q;
        flush_d          = flush_q;
        cnt_d            = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    ccr_d = ccr_next & CCR_MASK;
                    if (br_taken) begin
                        redirect_pc_d    = target_aligned;
                        redirect_valid_d = 1'b1;
                        state_d          = S_REDIRECT;
                    end
                end
            end
            S_REDIRECT: begin
                if (redirect_valid_q && redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    flush_d          = 1'b1;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                    state_d          = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The counter starts at FLUSH_CYCLES-1 and the exit happens
                // on the cycle it reads zero. This gives exactly
                // FLUSH_CYCLES cycles of flush.
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d          = S_IDLE;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                cnt_d            = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            ccr_reg_q        <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            ccr_reg_q        <= ccr_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            cnt_q            <= cnt_d;
        end
    end

    assign ccr_q          = ccr_reg_q;
    assign redirect_pc    = redirect_pc_q;
    assign redirect_valid = redirect_valid_q;
    assign flush          = flush_q;
    assign busy           = (state_q != S_IDLE);

`ifdef CCR_BRANCH_STATS_EN
    logic [15:0] br_count_q;

    // The counter saturates at all-ones instead of wrapping, so a full
    // counter still reads as "at least 65535".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q <= '0;
        end else if (acc && br_taken && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'd1;
        end
    end

    assign br_count = br_count_q;
`else
    assign br_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ccr_branch_unit.sv
module tb_ccr_branch_unit;

    localparam int XLEN         = 32;
    localparam int CCR_USED     = 9;
    localparam int FLUSH_CYCLES = 2;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic            stall;
    logic [31:0]     ccr_next;
    logic            br_taken;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] br_offset;
    logic [31:0]     ccr_q;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            flush;
    logic            busy;
    logic [15:0]     br_count;

    int compared;
    int mismatched;

    // Behavioural expectations, tracked at the transaction level.
    longint unsigned exp_ccr;
    longint unsigned exp_pc;
    int              exp_branches;

    ccr_branch_unit #(
        .XLEN(XLEN), .CCR_USED(CCR_USED), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall),
        .ccr_next(ccr_next), .br_taken(br_taken), .pc_in(pc_in),
        .br_offset(br_offset), .ccr_q(ccr_q), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .flush(flush), .busy(busy), .br_count(br_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The live CCR bits are kept and everything above them reads as zero.
    function automatic longint unsigned ccr_model(input longint unsigned v);
        return v % (64'd1 << CCR_USED);
    endfunction

    // Branch target = (pc + offset) mod 2^XLEN, rounded down to a multiple of 4.
    function automatic longint unsigned target_model(input longint unsigned pc, input longint unsigned off);
        longint unsigned t;
        t = (pc + off) % (64'd1 << XLEN);
        return t - (t % 4);
    endfunction

    function automatic longint unsigned count_model(input int n);
`ifdef CCR_BRANCH_STATS_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    task automatic drive_junk;
        valid_in = 1'b1;
        br_taken = 1'b1;
        stall    = 1'($urandom_range(0, 1));
        ccr_next = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
        pc_in    = $urandom;
        br_offset = $urandom;
    endtask

    task automatic idle_inputs;
        valid_in = 1'b0;
        br_taken = 1'b0;
        stall    = 1'b0;
        redirect_ready = 1'b0;
    endtask

    // One non-branch instruction presented for one cycle.
    task automatic commit(input logic [31:0] val, input logic stl, input logic vld);
        valid_in = vld;
        stall    = stl;
        br_taken = 1'b0;
        ccr_next = val;
        redirect_ready = 1'($urandom_range(0, 1));
        tick();
        if (vld && !stl) exp_ccr = ccr_model(val);
        idle_inputs();
        $display("commit  ccr_next=%08h stall=%0d valid=%0d -> ccr_q=%08h", val, stl, vld, ccr_q);
        check("commit_ccr", ccr_q, exp_ccr);
        check("commit_rv", redirect_valid, 0);
        check("commit_busy", busy, 0);
    endtask

    // A taken branch is accepted; the redirect must be up on the next cycle.
    task automatic start_branch(input logic [31:0] pc, input logic [31:0] off, input logic [31:0] ccr_val);
        valid_in  = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b1;
        ccr_next  = ccr_val;
        pc_in     = pc;
        br_offset = off;
        redirect_ready = 1'b0;
        tick();
        exp_ccr = ccr_model(ccr_val);
        exp_pc  = target_model(pc, off);
        exp_branches++;
        $display("branch  pc=%08h off=%08h -> redirect_pc=%08h", pc, off, redirect_pc);
        check("br_rv", redirect_valid, 1);
        check("br_pc", redirect_pc, exp_pc);
        check("br_busy", busy, 1);
        check("br_ccr", ccr_q, exp_ccr);
        check("br_flush", flush, 0);
        check("br_count", br_count, count_model(exp_branches));
    endtask

    // Hold off ready for `hold` cycles with junk inputs, then accept it.
    task automatic finish_redirect(input int hold);
        for (int i = 0; i < hold; i++) begin
            drive_junk();
            redirect_ready = 1'b0;
            tick();
            check("hold_rv", redirect_valid, 1);
            check("hold_pc", redirect_pc, exp_pc);
            check("hold_ccr", ccr_q, exp_ccr);
            check("hold_flush", flush, 0);
        end
        drive_junk();
        redirect_ready = 1'b1;
        tick();
        check("acc_rv", redirect_valid, 0);
        check("acc_flush", flush, 1);
    endtask

    // Count the cycles of flush, with a bound, while junk keeps arriving.
    task automatic run_flush;
        int n;
        n = 0;
        while (flush === 1'b1 && n < 20) begin
            check("fl_busy", busy, 1);
            drive_junk();
            redirect_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        idle_inputs();
        $display("flush   cycles=%0d busy=%0d ccr_q=%08h br_count=%0d", n, busy, ccr_q, br_count);
        check("fl_len", n, FLUSH_CYCLES);
        check("fl_idle", busy, 0);
        check("fl_rv", redirect_valid, 0);
        check("fl_ccr", ccr_q, exp_ccr);
        check("fl_count", br_count, count_model(exp_branches));
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        exp_ccr = 0;
        exp_pc = 0;
        exp_branches = 0;
        rst_n = 1'b0;
        idle_inputs();
        ccr_next = '0;
        pc_in = '0;
        br_offset = '0;
        repeat (2) tick();
        $display("reset   ccr_q=%08h rv=%0d flush=%0d busy=%0d", ccr_q, redirect_valid, flush, busy);
        check("rst_ccr", ccr_q, 0);
        check("rst_rv", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_flush", flush, 0);
        check("rst_busy", busy, 0);
        check("rst_count", br_count, 0);
        rst_n = 1'b1;
        tick();

        // CCR commit, then a stalled attempt and an invalid attempt.
        commit(32'hFFFF_FFFF, 1'b0, 1'b1);
        commit(32'h0000_0000, 1'b1, 1'b1);
        commit(32'h0000_0000, 1'b0, 1'b0);

        // Taken backwards branch with ready delayed for 3 cycles.
        start_branch(32'h0000_0100, 32'hFFFF_FFF0, 32'h0000_0055);
        finish_redirect(3);
        run_flush();

        // Wrap-around target with alignment, back to back with the previous one.
        start_branch(32'hFFFF_FFFC, 32'h0000_000A, 32'h0000_01AA);
        finish_redirect(0);
        run_flush();

        // Randomized mix of commits and branches.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                start_branch($urandom, $urandom, $urandom);
                finish_redirect($urandom_range(0, 3));
                run_flush();
            end else begin
                commit($urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0));
            end
        end

        // Asynchronous reset in the middle of a flush.
        commit(32'hFFFF_FFFF, 1'b0, 1'b1);
        start_branch(32'h0000_2000, 32'h0000_0040, 32'hFFFF_FFFF);
        finish_redirect(1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_ccr = 0;
        exp_branches = 0;
        $display("midrst  ccr_q=%08h rv=%0d flush=%0d busy=%0d", ccr_q, redirect_valid, flush, busy);
        check("mr_ccr", ccr_q, 0);
        check("mr_flush", flush, 0);
        check("mr_busy", busy, 0);
        check("mr_rv", redirect_valid, 0);
        check("mr_count", br_count, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_idle", busy, 0);
        commit(32'h0000_0123, 1'b0, 1'b1);
        start_branch(32'h0000_0400, 32'h0000_0004, 32'h0000_0001);
        finish_redirect(0);
        run_flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
